// File: rtl/mpcache_pkg.sv
// rtl/mpcache_pkg.sv - shared types for the multi-port cache ingress buffer
package mpcache_pkg;

  localparam int DEF_DATA_WIDTH = 64;

  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [DEF_DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_PKT  = 2'd1,
    IN_DROP = 2'd2
  } in_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_PKT  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mpcache_sdp_ram.sv
// rtl/mpcache_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module mpcache_sdp_ram #(
  parameter int AW = 8,
  parameter int W  = 66
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mpcache_ingress_buf.sv
// rtl/mpcache_ingress_buf.sv - per-port store-and-forward ingress buffer feeding a cache write port
module mpcache_ingress_buf
  import mpcache_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = 256,
  parameter int MAX_PKT_LEN = 64,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   in_vld,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   ready,
  output logic                   wr_vld,
  output logic                   wr_sop,
  output logic                   wr_eop,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAX_PKT_LEN + 1) + 1;
  localparam int EW = DATA_WIDTH + 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  in_state_t  in_state_q, in_state_d;
  out_state_t out_state_q, out_state_d;
  logic [PW-1:0] wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [LW-1:0] len_q, len_d;
  logic          vld_q, vld_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [EW-1:0] ram_wdata, ram_rdata;
  logic          commit, done, drop_inc, err_inc, start_sop;
  logic [PW-1:0] used_c, free_c;
  logic [LW-1:0] len_nxt;
  logic          free_ok, over_len;
  logic          rd_sop, rd_eop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Space is judged against the committed boundary: an sop always restarts at cp.
  assign used_c   = cp_q - rp_q;
  assign free_c   = PW'(DEPTH) - used_c;
  assign free_ok  = free_c >= PW'(MAX_PKT_LEN);
  assign len_nxt  = len_q + LW'(1);
  assign over_len = len_nxt > LW'(MAX_PKT_LEN);

  assign ram_waddr = start_sop ? cp_q[AW-1:0] : wp_q[AW-1:0];
  assign ram_wdata = {in_sop, in_eop, in_data};

  always_comb begin
    in_state_d = in_state_q;
    wp_d       = wp_q;
    cp_d       = cp_q;
    len_d      = len_q;
    ram_we     = 1'b0;
    commit     = 1'b0;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;
    start_sop  = 1'b0;
    if (in_vld) begin
      case (in_state_q)
        IN_IDLE: begin
          if (in_sop) start_sop = 1'b1;
          else        err_inc   = 1'b1;
        end
        IN_PKT: begin
          if (in_sop) begin
            err_inc   = 1'b1;
            start_sop = 1'b1;
          end else if (over_len) begin
            wp_d       = cp_q;
            drop_inc   = 1'b1;
            in_state_d = in_eop ? IN_IDLE : IN_DROP;
          end else begin
            ram_we = 1'b1;
            wp_d   = wp_q + PW'(1);
            len_d  = len_nxt;
            if (in_eop) begin
              cp_d       = wp_q + PW'(1);
              commit     = 1'b1;
              in_state_d = IN_IDLE;
            end
          end
        end
        IN_DROP: begin
          if (in_sop) begin
            err_inc   = 1'b1;
            start_sop = 1'b1;
          end else if (in_eop) begin
            in_state_d = IN_IDLE;
          end
        end
        default: in_state_d = IN_IDLE;
      endcase
      if (start_sop) begin
        if (free_ok) begin
          ram_we = 1'b1;
          wp_d   = cp_q + PW'(1);
          len_d  = LW'(1);
          if (in_eop) begin
            cp_d       = cp_q + PW'(1);
            commit     = 1'b1;
            in_state_d = IN_IDLE;
          end else begin
            in_state_d = IN_PKT;
          end
        end else begin
          wp_d       = cp_q;
          drop_inc   = 1'b1;
          in_state_d = in_eop ? IN_IDLE : IN_DROP;
        end
      end
    end
  end

  assign rd_sop  = ram_rdata[EW-1];
  assign rd_eop  = ram_rdata[EW-2];
  assign rd_data = ram_rdata[DATA_WIDTH-1:0];

  // The word after the current one is always fetched; rp only advances while eop is not on the output.
  always_comb begin
    out_state_d = out_state_q;
    rp_d        = rp_q;
    vld_d       = 1'b0;
    done        = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if ((pending_q != '0) && ready) begin
          rp_d        = rp_q + PW'(1);
          vld_d       = 1'b1;
          out_state_d = OUT_PKT;
        end
      end
      OUT_PKT: begin
        if (rd_eop) begin
          done        = 1'b1;
          out_state_d = OUT_IDLE;
        end else begin
          rp_d  = rp_q + PW'(1);
          vld_d = 1'b1;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (commit && !done)      pending_d = pending_q + PW'(1);
    else if (!commit && done) pending_d = pending_q - PW'(1);
    pkt_cnt_d  = sat_inc(pkt_cnt_q, done);
    drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
    err_cnt_d  = sat_inc(err_cnt_q, err_inc);
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      in_state_q <= IN_IDLE;
      wp_q       <= '0;
      cp_q       <= '0;
      len_q      <= '0;
    end else begin
      in_state_q <= in_state_d;
      wp_q       <= wp_d;
      cp_q       <= cp_d;
      len_q      <= len_d;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      out_state_q <= OUT_IDLE;
      rp_q        <= '0;
      vld_q       <= 1'b0;
      pending_q   <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_state_q <= out_state_d;
      rp_q        <= rp_d;
      vld_q       <= vld_d;
      pending_q   <= pending_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  mpcache_sdp_ram #(
    .AW (AW),
    .W  (EW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (vld_d),
    .rd_addr (rp_q[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // RAM output is unreset, so the word fields are qualified by the registered valid.
  assign wr_vld   = vld_q;
  assign wr_sop   = vld_q & rd_sop;
  assign wr_eop   = vld_q & rd_eop;
  assign wr_data  = vld_q ? rd_data : '0;
  assign level    = cp_q - rp_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mpcache_ingress_buf.sv
// tb/tb_mpcache_ingress_buf.sv - self-checking bench for mpcache_ingress_buf
module tb_mpcache_ingress_buf;

  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int MAXL  = 64;
  localparam int CW    = 16;
  localparam int LVW   = 9;

  logic clk = 1'b0;
  logic rst_in, in_vld, in_sop, in_eop, ready;
  logic [DW-1:0] in_data;
  logic wr_vld, wr_sop, wr_eop;
  logic [DW-1:0] wr_data;
  logic [LVW-1:0] level;
  logic [CW-1:0] pkt_cnt, drop_cnt, err_cnt;

  always #5 clk = ~clk;

  mpcache_ingress_buf #(
    .DATA_WIDTH (DW),
    .DEPTH (DEPTH),
    .MAX_PKT_LEN (MAXL),
    .CNT_W (CW)
  ) dut (
    .clk (clk), .rst_in (rst_in),
    .in_vld (in_vld), .in_sop (in_sop), .in_eop (in_eop), .in_data (in_data),
    .ready (ready),
    .wr_vld (wr_vld), .wr_sop (wr_sop), .wr_eop (wr_eop), .wr_data (wr_data),
    .level (level), .pkt_cnt (pkt_cnt), .drop_cnt (drop_cnt), .err_cnt (err_cnt)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  int tests = 0;
  int fails = 0;

  word_t exp_q[$];
  logic [DW-1:0] cur[$];
  bit m_in_pkt, m_in_drop;
  int m_level, m_drop, m_err, m_fwd, out_words;
  bit pv, pe;
  int t, eops, n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur.delete();
    m_in_pkt = 0; m_in_drop = 0;
    m_level = 0; m_drop = 0; m_err = 0; m_fwd = 0; out_words = 0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < cur.size(); i++)
      exp_q.push_back('{sop: (i == 0), eop: (i == cur.size() - 1), data: cur[i]});
    m_level += cur.size();
    cur.delete();
  endtask

  // Packet-level view: a packet reaches the cache only if it fits and is well framed.
  task automatic model_beat(input bit s, input bit e, input logic [DW-1:0] d);
    if (s) begin
      if (m_in_pkt || m_in_drop) m_err++;
      cur.delete();
      m_in_pkt = 0; m_in_drop = 0;
      if (DEPTH - m_level >= MAXL) begin
        cur.push_back(d);
        if (e) model_commit();
        else   m_in_pkt = 1;
      end else begin
        m_drop++;
        m_in_drop = !e;
      end
    end else if (m_in_pkt) begin
      cur.push_back(d);
      if (cur.size() > MAXL) begin
        m_drop++;
        cur.delete();
        m_in_pkt = 0;
        m_in_drop = !e;
      end else if (e) begin
        model_commit();
        m_in_pkt = 0;
      end
    end else if (m_in_drop) begin
      if (e) m_in_drop = 0;
    end else begin
      m_err++;
    end
  endtask

  task automatic beat(input bit s, input bit e, input logic [DW-1:0] d);
    @(negedge clk);
    in_vld = 1'b1; in_sop = s; in_eop = e; in_data = d;
    model_beat(s, e, d);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) beat(i == 0, i == len - 1, base + DW'(i));
    idle_in();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_in = 1'b1; ready = 1'b0;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    model_clear();
    @(posedge clk);
    #2;
    rst_in = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wr_vld) && k < bound) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0 || wr_vld) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_level"}, level, m_level);
    check({tag, "_pkt"}, pkt_cnt, m_fwd);
    check({tag, "_drop"}, drop_cnt, m_drop);
    check({tag, "_err"}, err_cnt, m_err);
  endtask

  // Output stream against the model queue, plus burst framing, every cycle.
  initial begin
    word_t w;
    pv = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        pv = 0; pe = 0;
      end else begin
        if (pv && !pe) check("burst_contig", wr_vld, 1);
        if (pv && pe)  check("idle_after_eop", wr_vld, 0);
        if (wr_vld) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got data 0x%0h expected no output", wr_data);
          end else begin
            w = exp_q.pop_front();
            check("wr_sop", wr_sop, w.sop);
            check("wr_eop", wr_eop, w.eop);
            check("wr_data", wr_data, w.data);
            out_words++;
            m_level--;
            if (w.eop) m_fwd++;
          end
        end
        pv = wr_vld;
        pe = wr_eop;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; ready = 1'b0;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_in = 1'b0;
    tick();
    check("rst_wr_vld", wr_vld, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_level", level, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_err", err_cnt, 0);

    // Single-word packet, then a stray word with no sop
    ready = 1'b1;
    beat(1, 1, 64'hA5);
    idle_in();
    tick();
    check("t1_vld", wr_vld, 1);
    check("t1_sop", wr_sop, 1);
    check("t1_eop", wr_eop, 1);
    check("t1_data", wr_data, 64'hA5);
    wait_drain(20);
    check("t1_pkt", pkt_cnt, 1);
    beat(0, 0, 64'h7);
    idle_in();
    tick();
    check("t1_err", err_cnt, 1);
    check_model("t1");

    // Three 8-word packets held back, then released
    do_reset();
    send_pkt(8, 64'h100);
    send_pkt(8, 64'h200);
    send_pkt(8, 64'h300);
    tick();
    check("t2_level", level, 24);
    check("t2_no_out", wr_vld, 0);
    ready = 1'b1;
    n = 0;
    while (!wr_vld && n < 20) begin tick(); n++; end
    check("t2_launch", wr_vld, 1);
    t = 1;
    eops = 0;
    while (eops < 3 && t < 100) begin
      tick();
      t++;
      if (wr_vld && wr_eop) eops++;
    end
    check("t2_span", t, 26);
    wait_drain(50);
    check("t2_pkt", pkt_cnt, 3);
    check_model("t2");

    // 200 words stored, next packet does not fit
    do_reset();
    for (int k = 0; k < 4; k++) send_pkt(50, 64'h1000 * (k + 1));
    tick();
    check("t3_level_fill", level, 200);
    send_pkt(10, 64'h9000);
    tick();
    check("t3_drop", drop_cnt, 1);
    check("t3_level_keep", level, 200);
    check_model("t3a");
    ready = 1'b1;
    wait_drain(400);
    check("t3_pkt", pkt_cnt, 4);
    check_model("t3b");

    // Truncated packet restarted by a new sop
    do_reset();
    ready = 1'b1;
    beat(1, 0, 64'hA0);
    beat(0, 0, 64'hA1);
    beat(0, 0, 64'hA2);
    send_pkt(4, 64'hB0);
    wait_drain(50);
    check("t4_err", err_cnt, 1);
    check("t4_pkt", pkt_cnt, 1);
    check("t4_words", out_words, 4);
    check_model("t4");

    // Over-length packet followed by a legal one
    do_reset();
    ready = 1'b1;
    send_pkt(65, 64'h5000);
    repeat (3) tick();
    check("t5_drop", drop_cnt, 1);
    check("t5_no_words", out_words, 0);
    check("t5_level", level, 0);
    send_pkt(4, 64'h6000);
    wait_drain(50);
    check("t5_pkt", pkt_cnt, 1);
    check("t5_words", out_words, 4);
    check_model("t5");

    // Reset in the middle of an output burst
    do_reset();
    ready = 1'b1;
    send_pkt(8, 64'h7000);
    n = 0;
    while (!wr_vld && n < 20) begin tick(); n++; end
    check("t6_burst", wr_vld, 1);
    tick();
    tick();
    @(posedge clk);
    #2;
    rst_in = 1'b1;
    #1;
    check("t6_vld", wr_vld, 0);
    check("t6_sop", wr_sop, 0);
    check("t6_eop", wr_eop, 0);
    check("t6_data", wr_data, 0);
    check("t6_level", level, 0);
    check("t6_pkt0", pkt_cnt, 0);
    model_clear();
    @(posedge clk);
    #2;
    rst_in = 1'b0;
    send_pkt(2, 64'h8000);
    wait_drain(50);
    check("t6_pkt", pkt_cnt, 1);
    check("t6_words", out_words, 2);
    check_model("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mpcache_ingress_buf.md
Name: mpcache_ingress_buf

Overview:
- Per-port store-and-forward ingress buffer, directly upstream of the multi-port cache write side; one instance per input port.
- Accepts a raw sop/eop/vld packet stream and holds each packet until its eop word is stored.
- Sends a whole packet to the cache write port in one back-to-back burst, starting only when the cache port's ready is high.
- Discards partial, malformed and non-fitting packets so the cache never sees a broken frame.

Parameters:
- DATA_WIDTH, 64, payload word width.
- DEPTH, 256, buffer words; power of two.
- MAX_PKT_LEN, 64, longest legal packet in words; must be at most DEPTH.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_in  in  1  asynchronous reset, active-high.
- in_vld  in  1  input word valid.
- in_sop  in  1  first word of packet; qualified by in_vld.
- in_eop  in  1  last word of packet; qualified by in_vld.
- in_data  in  DATA_WIDTH  input payload.
- ready  in  1  cache port may accept a new packet.
- wr_vld  out  1  word valid toward cache.
- wr_sop  out  1  first word toward cache.
- wr_eop  out  1  last word toward cache.
- wr_data  out  DATA_WIDTH  payload toward cache.
- level  out  $clog2(DEPTH)+1  committed words held.
- pkt_cnt  out  CNT_W  packets forwarded.
- drop_cnt  out  CNT_W  packets dropped for lack of space or over-length.
- err_cnt  out  CNT_W  framing errors.

Behaviour:
- Reset: all outputs 0; pointers 0; both FSMs idle. A reset mid-packet discards everything, including a partially sent packet; the cache port sees wr_vld fall with no eop.
- Storage: each entry holds {sop, eop, data}.
  - Write pointer wp is speculative; commit pointer cp marks the end of the last complete packet; read pointer rp is the output side.
  - level = cp - rp.
  - Speculative free space = DEPTH - (wp - rp).
- Input FSM, states IN_IDLE, IN_PKT, IN_DROP:
  - IN_IDLE, in_vld with in_sop: if free space >= MAX_PKT_LEN, write the word, then go to IN_PKT, or commit immediately if in_eop is also high. Otherwise go to IN_DROP and increment drop_cnt.
  - IN_IDLE, in_vld without in_sop: ignore the word; err_cnt++.
  - IN_PKT, in_vld without sop or eop: write the word. If the packet length would exceed MAX_PKT_LEN, rewind wp to cp, increment drop_cnt and go to IN_DROP.
  - IN_PKT, in_vld with in_eop: write the word; cp <= wp+1; increment pending; go to IN_IDLE.
  - IN_PKT, in_vld with in_sop: rewind wp to cp; err_cnt++; restart the packet using the IN_IDLE sop rules on this same word.
  - IN_DROP: discard words until in_eop, then go to IN_IDLE. An sop in IN_DROP is handled as in IN_IDLE, with err_cnt++.
- Output FSM, states OUT_IDLE, OUT_PKT:
  - OUT_IDLE: when pending > 0 and ready = 1, read the entry at rp and go to OUT_PKT.
  - Output is registered: the first wr_vld, with wr_sop, appears 1 cycle after the launch decision.
  - Minimum latency from the in_eop beat to wr_sop is 2 cycles.
  - OUT_PKT: one word per cycle with wr_vld continuously high. ready is ignored mid-packet; it is sampled only at launch.
  - On the word carrying eop: pending--, pkt_cnt++, go to OUT_IDLE. The next packet may launch on the following cycle, giving 1 idle cycle between packets.
- Simultaneous commit and output-complete in one cycle: pending is unchanged.
- Pointers are $clog2(DEPTH)+1 bits with natural wrap.
- The statistics counters saturate at all-ones.
- A single-word packet (sop and eop on the same beat) is legal in both directions.

Decomposition:
- mpcache_pkg holds:
  - the entry struct {sop, eop, data};
  - enums in_state_t and out_state_t;
  - default DATA_WIDTH.
- One sub-module, mpcache_sdp_ram: simple dual-port RAM with 1-cycle registered read, DEPTH x (DATA_WIDTH+2).

Test Plan:
- Single-word packet, data 0xA5, with ready=1 -> wr_sop=wr_eop=wr_vld=1 and wr_data 0xA5 two cycles after input; pkt_cnt=1.
- Three 8-word packets back to back while ready=0, then ready=1 -> level=24; 24 contiguous output words per packet order with 1 idle cycle between packets; pkt_cnt=3.
- DEPTH=256, MAX_PKT_LEN=64: fill 200 words with ready=0, then send a new packet -> dropped; drop_cnt=1; level stays 200.
- Sop, 3 words, then a second sop -> first packet discarded, err_cnt=1, only the second packet is output.
- A 65-word packet -> drop_cnt=1, no output; a following 4-word packet passes intact.
- Assert rst_in during an output burst -> all outputs 0 the same cycle; level=0; a new packet after reset passes normally.
